// File: rtl/fc_by_aim_pkg.sv
// fc_by_aim_pkg
// Shared definitions for the fully-connected AIM output layer:
//   - layer geometry constants (N_OUT, DATA_W, OUT_W)
//   - FSM state encoding
//   - constant input-vector and weight ROM functions
//   - 16-bit signed saturation helper
// Optional feature macro used by the layer: FC_BY_AIM_RELU_EN.
package fc_by_aim_pkg;

  localparam int N_OUT  = 10;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Input activation x[i] = (i mod 16) - 8, range -8..7.
  function automatic logic signed [DATA_W-1:0] x_rom(input int i);
    int v;
    v = (i % 16) - 8;
    return DATA_W'(v);
  endfunction

  // Weight w[j][i] = (((i + j) mod 4) - 1) * gain, range -gain..2*gain.
  // gain <= 63 keeps every weight inside signed 8-bit.
  function automatic logic signed [DATA_W-1:0] w_rom(input int j, input int i, input int gain);
    int v;
    v = (((i + j) % 4) - 1) * gain;
    return DATA_W'(v);
  endfunction

  // Clamp a sign-extended accumulator value into [-32768, 32767].
  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [63:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > 64'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -64'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_aim_neuron.sv
// fc_aim_neuron
// One neuron of the AIM layer: a single signed 8x8 multiplier feeding an
// ACC_W-bit accumulator, plus the registered saturating output score.
// With FC_BY_AIM_RELU_EN defined, negative saturated scores load as 0.
// Ports:
//   clk      rising-edge clock
//   clr_i    synchronous clear of accumulator and output score
//   en_i     accumulate x_i * w_i this cycle
//   ld_i     load sat16(acc) (optionally ReLU'd) into the output score
//   x_i      signed input activation
//   w_i      signed weight
//   score_o  registered signed score
module fc_aim_neuron
  import fc_by_aim_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     ld_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [OUT_W-1:0]  score_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0]    sat_val;
  logic signed [OUT_W-1:0]    score_q, score_d;

  assign prod     = x_i * w_i;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sat_val  = sat16({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q});

  always_comb begin
    acc_d   = acc_q;
    score_d = score_q;
    if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
    if (ld_i) begin
`ifdef FC_BY_AIM_RELU_EN
      score_d = sat_val[OUT_W-1] ? '0 : sat_val;
`else
      score_d = sat_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      acc_q   <= '0;
      score_q <= '0;
    end else begin
      acc_q   <= acc_d;
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/fc_by_aim.sv
// fc_by_aim
// Self-contained 10-neuron fully-connected output layer. All neurons run in
// parallel; each walks the constant input vector serially, one MAC per clock.
// After N_IN MAC cycles a single LOAD cycle registers the saturated scores,
// then the block parks in DONE until the next reset.
// Optional feature macro: FC_BY_AIM_RELU_EN (clamps negative scores to 0).
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset; restarts the computation
//   OR1_1..OR1_10  registered signed 16-bit scores of neurons 1..10
module fc_by_aim
  import fc_by_aim_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int W_GAIN = 1,
  parameter int ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic signed [OUT_W-1:0] OR1_1,
  output logic signed [OUT_W-1:0] OR1_2,
  output logic signed [OUT_W-1:0] OR1_3,
  output logic signed [OUT_W-1:0] OR1_4,
  output logic signed [OUT_W-1:0] OR1_5,
  output logic signed [OUT_W-1:0] OR1_6,
  output logic signed [OUT_W-1:0] OR1_7,
  output logic signed [OUT_W-1:0] OR1_8,
  output logic signed [OUT_W-1:0] OR1_9,
  output logic signed [OUT_W-1:0] OR1_10
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] w_cur [N_OUT];
  logic signed [OUT_W-1:0]  score [N_OUT];
  logic                     mac_en, load_en, clr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = LOAD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      LOAD:    state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reset is applied to the neurons as a synchronous clear so that a reset
  // in any state discards partial sums and zeroes the scores on that edge.
  assign clr     = ~rst_n;
  assign mac_en  = (state_q == RUN);
  assign load_en = (state_q == LOAD);
  assign x_cur   = x_rom(int'(idx_q));

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_neuron
    assign w_cur[gi] = w_rom(gi, int'(idx_q), W_GAIN);

    fc_aim_neuron #(
      .ACC_W (ACC_W)
    ) u_neuron (
      .clk     (clk),
      .clr_i   (clr),
      .en_i    (mac_en),
      .ld_i    (load_en),
      .x_i     (x_cur),
      .w_i     (w_cur[gi]),
      .score_o (score[gi])
    );
  end

  assign OR1_1  = score[0];
  assign OR1_2  = score[1];
  assign OR1_3  = score[2];
  assign OR1_4  = score[3];
  assign OR1_5  = score[4];
  assign OR1_6  = score[5];
  assign OR1_7  = score[6];
  assign OR1_8  = score[7];
  assign OR1_9  = score[8];
  assign OR1_10 = score[9];

endmodule

// File: tb/tb_fc_by_aim.sv
// tb_fc_by_aim
// Directed bench for fc_by_aim: a default instance (W_GAIN = 1) and a
// W_GAIN = 3 instance share clock and reset. Expected scores are hand-derived
// from the ROM definitions; ReLU expectations apply when FC_BY_AIM_RELU_EN is
// defined for the build.
module tb_fc_by_aim;

  logic clk;
  logic rst_n;

  logic signed [15:0] out_a [10];
  logic signed [15:0] out_g [10];
  logic signed [15:0] exp_a [10];
  logic signed [15:0] exp_g [10];

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fc_by_aim dut_a (
    .clk(clk), .rst_n(rst_n),
    .OR1_1(out_a[0]), .OR1_2(out_a[1]), .OR1_3(out_a[2]), .OR1_4(out_a[3]),
    .OR1_5(out_a[4]), .OR1_6(out_a[5]), .OR1_7(out_a[6]), .OR1_8(out_a[7]),
    .OR1_9(out_a[8]), .OR1_10(out_a[9])
  );

  fc_by_aim #(.W_GAIN(3)) dut_g (
    .clk(clk), .rst_n(rst_n),
    .OR1_1(out_g[0]), .OR1_2(out_g[1]), .OR1_3(out_g[2]), .OR1_4(out_g[3]),
    .OR1_5(out_g[4]), .OR1_6(out_g[5]), .OR1_7(out_g[6]), .OR1_8(out_g[7]),
    .OR1_9(out_g[8]), .OR1_10(out_g[9])
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_expected();
    int base [10];
    base = '{16, -8, -16, -8, 16, -8, -16, -8, 16, -8};
    for (int j = 0; j < 10; j++) begin
`ifdef FC_BY_AIM_RELU_EN
      exp_a[j] = (base[j] < 0) ? 16'sd0 : 16'(base[j]);
      exp_g[j] = (base[j] < 0) ? 16'sd0 : 16'(base[j] * 3);
`else
      exp_a[j] = 16'(base[j]);
      exp_g[j] = 16'(base[j] * 3);
`endif
    end
  endtask

  // Five cycles of reset: every score reads 0 on every cycle.
  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (out_a[j] !== 16'sd0 || out_g[j] !== 16'sd0) begin
          errors++;
          $display("FAIL reset cyc%0d OR1_%0d: got a=%0d g=%0d want 0", c, j + 1, out_a[j], out_g[j]);
        end
      end
    end
  endtask

  // Release reset and run: zero through edge 16, default scores at edge 17.
  task automatic run_after_release(input string tag);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (out_a[j] !== 16'sd0 || out_g[j] !== 16'sd0) begin
          errors++;
          $display("FAIL %s edge%0d OR1_%0d: got a=%0d g=%0d want 0", tag, e, j + 1, out_a[j], out_g[j]);
        end
      end
    end
    step();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (out_a[j] !== exp_a[j]) begin
        errors++;
        $display("FAIL %s edge17 OR1_%0d: got %0d want %0d", tag, j + 1, out_a[j], exp_a[j]);
      end
    end
    $display("%s: edge17 scores %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d", tag,
             out_a[0], out_a[1], out_a[2], out_a[3], out_a[4],
             out_a[5], out_a[6], out_a[7], out_a[8], out_a[9]);
  endtask

  task automatic test_default_run();
    run_after_release("default_run");
    for (int c = 0; c < 100; c++) begin
      step();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (out_a[j] !== exp_a[j]) begin
          errors++;
          $display("FAIL hold cyc%0d OR1_%0d: got %0d want %0d", c, j + 1, out_a[j], exp_a[j]);
        end
      end
    end
  endtask

  // The W_GAIN = 3 instance has been in DONE alongside the default one.
  task automatic test_gain();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (out_g[j] !== exp_g[j]) begin
        errors++;
        $display("FAIL gain3 OR1_%0d: got %0d want %0d", j + 1, out_g[j], exp_g[j]);
      end
    end
    $display("gain3: scores %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d",
             out_g[0], out_g[1], out_g[2], out_g[3], out_g[4],
             out_g[5], out_g[6], out_g[7], out_g[8], out_g[9]);
  endtask

  // Reset sampled at edge 8 of a run, held for 2 edges, then a clean rerun.
  task automatic test_mid_reset();
    rst_n = 1'b0;
    step();
    run_after_release("mid_prep");
    // Restart from DONE, then interrupt at edge 8.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) step();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (out_a[j] !== 16'sd0 || out_g[j] !== 16'sd0) begin
          errors++;
          $display("FAIL mid_reset low%0d OR1_%0d: got a=%0d g=%0d want 0", c, j + 1, out_a[j], out_g[j]);
        end
      end
    end
    run_after_release("mid_reset");
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (out_g[j] !== exp_g[j]) begin
        errors++;
        $display("FAIL mid_reset gain3 OR1_%0d: got %0d want %0d", j + 1, out_g[j], exp_g[j]);
      end
    end
  endtask

  // Reset while in DONE: scores clear on that edge, then recompute.
  task automatic test_done_reset();
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    step();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (out_a[j] !== 16'sd0 || out_g[j] !== 16'sd0) begin
        errors++;
        $display("FAIL done_reset clear OR1_%0d: got a=%0d g=%0d want 0", j + 1, out_a[j], out_g[j]);
      end
    end
    run_after_release("done_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    set_expected();
    #1;
    test_reset();
    test_default_run();
    test_gain();
    test_mid_reset();
    test_done_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
